color_point_detector: RTL and testbench

COLOR_POINT_DETECTOR -- requirements
Module: color_point_detector

---
 rtl/color_point_detector.sv | 267 ++++++++++++++++++++++++++
 tb/tb_color_point_detector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/color_point_detector.sv
// Colour point detector: classifies YCrCb pixels into four colour classes,
// reports a point once RUN_MIN consecutive same-class pixels are seen on a
// line, and raises frame_flag through vertical blanking for downstream use.
module color_point_detector #(
  parameter int         H_ACTIVE = 640,
  parameter int         V_ACTIVE = 480,
  parameter int         RUN_MIN  = 4,
  parameter int         FLAG_MIN = 64,
  parameter logic [7:0] Y_MIN    = 8'd40,
  parameter logic [7:0] CR_HI    = 8'd160,
  parameter logic [7:0] CR_LO    = 8'd112,
  parameter logic [7:0] CB_HI    = 8'd160,
  parameter logic [7:0] CB_LO    = 8'd112
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_valid,
  input  logic [7:0] pixel_y,
  input  logic [7:0] pixel_cr,
  input  logic [7:0] pixel_cb,
  input  logic       sol,
  input  logic       sof,
  output logic [1:0] color,
  output logic [9:0] interesting_x,
  output logic [8:0] interesting_y,
  output logic       interesting_flag,
  output logic       frame_flag,
  output logic       overrun
);

  localparam int              BW       = $clog2(FLAG_MIN + 1);
  localparam logic [9:0]      H_LIM    = 10'(H_ACTIVE);
  localparam logic [8:0]      V_LIM    = 9'(V_ACTIVE);
  localparam logic [3:0]      RUN_LIM  = 4'(RUN_MIN);
  localparam logic [BW-1:0]   FLAG_LIM = BW'(FLAG_MIN);
  localparam logic [BW-1:0]   B_ONE    = BW'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, BLANK} state_e;

  state_e        state_q, state_d;
  logic [9:0]    x_q, x_d, x_eff;
  logic [8:0]    y_q, y_d, y_eff;
  logic          line_start_q, line_start_d, first_eff;
  logic          drain_q, drain_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          frame_flag_q, frame_flag_d;
  logic          overrun_q, overrun_d;
  logic          accept;

  logic          cls_hit;
  logic [1:0]    cls;

  // [0]: stage-1 holds an accepted pixel, [1]: stage-2 holds a point to emit
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  logic          s1_hit_q, s1_hit_d, s1_first_q, s1_first_d;
  logic [1:0]    s1_cls_q, s1_cls_d, prev_cls_q, prev_cls_d, s2_cls_q, s2_cls_d;
  logic [9:0]    s1_x_q, s1_x_d, s2_x_q, s2_x_d;
  logic [8:0]    s1_y_q, s1_y_d, s2_y_q, s2_y_d;
  logic [3:0]    run_q, run_d;
  logic [1:0]    color_q, color_d;
  logic [9:0]    ix_q, ix_d;
  logic [8:0]    iy_q, iy_d;
  logic          iflag_q, iflag_d;

  // Colour class of the incoming pixel, first matching rule wins
  always_comb begin
    cls_hit = 1'b0;
    cls     = 2'd0;
    if (pixel_y >= Y_MIN) begin
      if (pixel_cr >= CR_HI && pixel_cb < CB_LO) begin
        cls_hit = 1'b1; cls = 2'd0;
      end else if (pixel_cb >= CB_HI && pixel_cr < CR_LO) begin
        cls_hit = 1'b1; cls = 2'd1;
      end else if (pixel_cr < CR_LO && pixel_cb < CB_LO) begin
        cls_hit = 1'b1; cls = 2'd2;
      end else if (pixel_cr >= CR_HI && pixel_cb >= CB_HI) begin
        cls_hit = 1'b1; cls = 2'd3;
      end
    end
  end

  // Frame FSM, raster counters, blanking timer and overrun tracking
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_start_d = line_start_q;
    drain_d      = drain_q;
    blank_d      = blank_q;
    frame_flag_d = frame_flag_q;
    overrun_d    = overrun_q;
    x_eff        = x_q;
    y_eff        = y_q;
    first_eff    = line_start_q;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof) begin
          state_d      = ACTIVE;
          x_d          = '0;
          y_d          = '0;
          line_start_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (sof) begin
          // truncated frame: drain what is in flight, do not restart
          state_d   = DRAIN;
          drain_d   = 1'b0;
          overrun_d = 1'b1;
        end else begin
          // a pixel arriving with sol already belongs to the new line
          if (sol) begin
            x_eff     = '0;
            y_eff     = (y_q < V_LIM) ? y_q + 9'd1 : y_q;
            first_eff = 1'b1;
          end
          x_d          = x_eff;
          y_d          = y_eff;
          line_start_d = first_eff;
          if (pixel_valid) begin
            accept = (x_eff < H_LIM) && (y_eff < V_LIM);
            if (x_eff < H_LIM) x_d = x_eff + 10'd1;
            if (accept) begin
              line_start_d = 1'b0;
              if (x_eff == H_LIM - 10'd1 && y_eff == V_LIM - 9'd1) begin
                state_d = DRAIN;
                drain_d = 1'b0;
              end
            end
          end
        end
      end
      DRAIN: begin
        // two cycles lets the last point leave before frame_flag rises
        drain_d = 1'b1;
        if (sof) overrun_d = 1'b1;
        if (drain_q) begin
          state_d = BLANK;
          blank_d = '0;
        end
      end
      BLANK: begin
        frame_flag_d = 1'b1;
        // count only cycles frame_flag is actually visible to consumers
        if (frame_flag_q && blank_q < FLAG_LIM) blank_d = blank_q + B_ONE;
        if (sof) begin
          if (blank_q >= FLAG_LIM) begin
            state_d      = ACTIVE;
            frame_flag_d = 1'b0;
            x_d          = '0;
            y_d          = '0;
            line_start_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Classify -> run count -> output register pipeline
  always_comb begin
    vld_pipe_d    = {1'b0, accept};
    s1_hit_d      = s1_hit_q;
    s1_cls_d      = s1_cls_q;
    s1_first_d    = s1_first_q;
    s1_x_d        = s1_x_q;
    s1_y_d        = s1_y_q;
    run_d         = run_q;
    prev_cls_d    = prev_cls_q;
    s2_cls_d      = s2_cls_q;
    s2_x_d        = s2_x_q;
    s2_y_d        = s2_y_q;
    color_d       = color_q;
    ix_d          = ix_q;
    iy_d          = iy_q;
    iflag_d       = vld_pipe_q[1];
    if (accept) begin
      s1_hit_d   = cls_hit;
      s1_cls_d   = cls;
      s1_first_d = first_eff;
      s1_x_d     = x_eff;
      s1_y_d     = y_eff;
    end
    if (vld_pipe_q[0]) begin
      if (!s1_hit_q)
        run_d = 4'd0;
      else if (s1_first_q || run_q == 4'd0 || s1_cls_q != prev_cls_q)
        run_d = 4'd1;
      else if (run_q < RUN_LIM)
        run_d = run_q + 4'd1;
      prev_cls_d    = s1_cls_q;
      vld_pipe_d[1] = s1_hit_q && (run_d == RUN_LIM);
      s2_cls_d      = s1_cls_q;
      s2_x_d        = s1_x_q;
      s2_y_d        = s1_y_q;
    end
    if (vld_pipe_q[1]) begin
      color_d = s2_cls_q;
      ix_d    = s2_x_q;
      iy_d    = s2_y_q;
    end
  end

  // State registers; reset aborts any frame in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      line_start_q <= 1'b0;
      drain_q      <= 1'b0;
      blank_q      <= '0;
      frame_flag_q <= 1'b0;
      overrun_q    <= 1'b0;
      vld_pipe_q   <= '0;
      s1_hit_q     <= 1'b0;
      s1_cls_q     <= '0;
      s1_first_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      run_q        <= '0;
      prev_cls_q   <= '0;
      s2_cls_q     <= '0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      color_q      <= '0;
      ix_q         <= '0;
      iy_q         <= '0;
      iflag_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_start_q <= line_start_d;
      drain_q      <= drain_d;
      blank_q      <= blank_d;
      frame_flag_q <= frame_flag_d;
      overrun_q    <= overrun_d;
      vld_pipe_q   <= vld_pipe_d;
      s1_hit_q     <= s1_hit_d;
      s1_cls_q     <= s1_cls_d;
      s1_first_q   <= s1_first_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      run_q        <= run_d;
      prev_cls_q   <= prev_cls_d;
      s2_cls_q     <= s2_cls_d;
      s2_x_q       <= s2_x_d;
      s2_y_q       <= s2_y_d;
      color_q      <= color_d;
      ix_q         <= ix_d;
      iy_q         <= iy_d;
      iflag_q      <= iflag_d;
    end
  end

  assign color            = color_q;
  assign interesting_x    = ix_q;
  assign interesting_y    = iy_q;
  assign interesting_flag = iflag_q;
  assign frame_flag       = frame_flag_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_color_point_detector.sv
// Directed bench for color_point_detector on an 8x4 raster, RUN_MIN=3,
// FLAG_MIN=16. Each pixel carries its own hand-derived expectation, which
// is checked two clocks later when the point would reach the outputs.
module tb_color_point_detector;
  logic       clk = 1'b0, reset = 1'b0;
  logic       pixel_valid = 1'b0, sol = 1'b0, sof = 1'b0;
  logic [7:0] pixel_y = '0, pixel_cr = '0, pixel_cb = '0;
  logic [1:0] color;
  logic [9:0] interesting_x;
  logic [8:0] interesting_y;
  logic       interesting_flag, frame_flag, overrun;

  int n_chk = 0;
  int errs  = 0;

  // expected-point delay line, [2] lines up with the DUT outputs
  logic       ep[3];
  logic [1:0] ec[3];
  logic [9:0] ex[3];
  logic [8:0] ey[3];

  color_point_detector #(
    .H_ACTIVE(8), .V_ACTIVE(4), .RUN_MIN(3), .FLAG_MIN(16)
  ) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid),
    .pixel_y(pixel_y), .pixel_cr(pixel_cr), .pixel_cb(pixel_cb),
    .sol(sol), .sof(sof), .color(color),
    .interesting_x(interesting_x), .interesting_y(interesting_y),
    .interesting_flag(interesting_flag), .frame_flag(frame_flag),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 3; i++) begin
      ep[i] = 1'b0; ec[i] = '0; ex[i] = '0; ey[i] = '0;
    end
  endtask

  // k: 0..3 class, 4 dark (Y below threshold), 5 neutral chroma
  task automatic cyc(input logic f, input logic s, input logic v, input int k,
                     input logic e, input int x, input int y);
    sof = f; sol = s; pixel_valid = v;
    case (k)
      0:       begin pixel_y = 8'd80; pixel_cr = 8'd200; pixel_cb = 8'd50;  end
      1:       begin pixel_y = 8'd80; pixel_cr = 8'd50;  pixel_cb = 8'd200; end
      2:       begin pixel_y = 8'd80; pixel_cr = 8'd50;  pixel_cb = 8'd50;  end
      3:       begin pixel_y = 8'd80; pixel_cr = 8'd200; pixel_cb = 8'd200; end
      4:       begin pixel_y = 8'd20; pixel_cr = 8'd200; pixel_cb = 8'd50;  end
      default: begin pixel_y = 8'd80; pixel_cr = 8'd130; pixel_cb = 8'd130; end
    endcase
    @(posedge clk); #1;
    sof = 1'b0; sol = 1'b0; pixel_valid = 1'b0;
    for (int i = 2; i > 0; i--) begin
      ep[i] = ep[i-1]; ec[i] = ec[i-1]; ex[i] = ex[i-1]; ey[i] = ey[i-1];
    end
    ep[0] = e; ec[0] = 2'(k); ex[0] = 10'(x); ey[0] = 9'(y);
    chk($sformatf("flag@%0d,%0d", ex[2], ey[2]), 32'(interesting_flag), 32'(ep[2]));
    if (ep[2]) begin
      chk("color", 32'(color), 32'(ec[2]));
      chk("x", 32'(interesting_x), 32'(ex[2]));
      chk("y", 32'(interesting_y), 32'(ey[2]));
    end
  endtask

  task automatic pix(input int k, input logic s, input logic e, input int x, input int y);
    cyc(1'b0, s, 1'b1, k, e, x, y);
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) cyc(1'b0, s, 1'b0, 5, 1'b0, 0, 0);
  endtask

  task automatic sofc();
    cyc(1'b1, 1'b1, 1'b0, 5, 1'b0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_color"}, 32'(color), 32'd0);
    chk({tag, "_x"}, 32'(interesting_x), 32'd0);
    chk({tag, "_y"}, 32'(interesting_y), 32'd0);
    chk({tag, "_iflag"}, 32'(interesting_flag), 32'd0);
    chk({tag, "_fflag"}, 32'(frame_flag), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    clear_exp();
    #12;
    chk_zero("reset");
    @(negedge clk); reset = 1'b1;

    // IDLE: pixels before the first sof are dropped
    for (int i = 0; i < 3; i++) pix(0, 1'b0, 1'b0, 0, 0);
    chk("idle_fflag", 32'(frame_flag), 32'd0);

    // Frame 1, line 0: run of class 0 from x=2, points at x=4 and x=5
    sofc();
    pix(5, 1'b0, 1'b0, 0, 0);
    pix(5, 1'b0, 1'b0, 1, 0);
    for (int x = 2; x < 6; x++) pix(0, 1'b0, x >= 4, x, 0);
    pix(4, 1'b0, 1'b0, 6, 0);
    pix(3, 1'b0, 1'b0, 7, 0);
    // line 1: sol with first pixel, class change restarts the run
    pix(1, 1'b1, 1'b0, 0, 1);
    pix(1, 1'b0, 1'b0, 1, 1);
    for (int x = 2; x < 5; x++) pix(2, 1'b0, x == 4, x, 1);
    pix(3, 1'b0, 1'b0, 5, 1);
    pix(3, 1'b0, 1'b0, 6, 1);
    // line 2: sol mid-run of class 3 -> run restarts, point at x=2
    idle(1, 1'b1);
    for (int x = 0; x < 3; x++) pix(3, 1'b0, x == 2, x, 2);
    for (int x = 3; x < 8; x++) pix(4, 1'b0, 1'b0, x, 2);
    // line 3: all class 1, points from x=2 to the last pixel
    idle(1, 1'b1);
    for (int x = 0; x < 8; x++) pix(1, 1'b0, x >= 2, x, 3);
    idle(1, 1'b0);
    chk("drain1_fflag", 32'(frame_flag), 32'd0);
    idle(1, 1'b0);
    chk("drain2_fflag", 32'(frame_flag), 32'd0);
    idle(1, 1'b0);
    chk("blank_fflag", 32'(frame_flag), 32'd1);
    chk("blank_overrun", 32'(overrun), 32'd0);

    // BLANK: pixels ignored, early sof flags overrun and is ignored
    for (int i = 0; i < 3; i++) pix(0, 1'b1, 1'b0, 0, 0);
    idle(1, 1'b0);
    sofc();
    chk("early_sof_overrun", 32'(overrun), 32'd1);
    chk("early_sof_fflag", 32'(frame_flag), 32'd1);
    idle(10, 1'b0);
    sofc();
    chk("sof_at_15_fflag", 32'(frame_flag), 32'd1);
    sofc();
    chk("sof_at_16_fflag", 32'(frame_flag), 32'd0);

    // Frame 2 restarts at (0,0)
    for (int x = 0; x < 3; x++) pix(2, 1'b0, x == 2, x, 0);
    idle(2, 1'b1);
    pix(3, 1'b0, 1'b0, 0, 2);
    pix(3, 1'b0, 1'b0, 1, 2);
    pix(3, 1'b0, 1'b0, 2, 2);
    chk("pre_reset_overrun", 32'(overrun), 32'd1);
    chk("pre_reset_x", 32'(interesting_x), 32'd2);
    chk("pre_reset_color", 32'(color), 32'd2);

    // Asynchronous reset mid-line: outputs clear at once, pending point lost
    reset = 1'b0;
    #1;
    chk_zero("async_reset");
    clear_exp();
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    pix(3, 1'b0, 1'b0, 3, 2);
    pix(3, 1'b1, 1'b0, 0, 3);
    pix(3, 1'b0, 1'b0, 1, 3);
    pix(3, 1'b0, 1'b0, 2, 3);
    idle(2, 1'b0);
    chk("post_reset_fflag", 32'(frame_flag), 32'd0);
    chk("post_reset_overrun", 32'(overrun), 32'd0);

    // Frame 3: dark pixels on line 2 then sof at (3,2) truncates the frame
    sofc();
    idle(2, 1'b1);
    for (int x = 0; x < 3; x++) pix(4, 1'b0, 1'b0, x, 2);
    cyc(1'b1, 1'b1, 1'b1, 0, 1'b0, 3, 2);
    chk("trunc_overrun", 32'(overrun), 32'd1);
    idle(1, 1'b0);
    chk("trunc_drain1_fflag", 32'(frame_flag), 32'd0);
    idle(1, 1'b0);
    chk("trunc_drain2_fflag", 32'(frame_flag), 32'd0);
    idle(1, 1'b0);
    chk("trunc_blank_fflag", 32'(frame_flag), 32'd1);
    idle(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, errs);
    $finish;
  end

  // Hard stop so a wedged run still reports
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
